// File: rtl/cherry_pkg.sv
// Shared constants for the instruction-queue producer/consumer pair.
// Holds the instruction type encodings, superscalar width and address/count
// widths used by both iq_issuer and instruction_queue.
package cherry_pkg;

  localparam int unsigned LOG_SUPERSCALAR_WIDTH = 4;
  localparam int unsigned SUPERSCALAR_WIDTH     = 2 ** LOG_SUPERSCALAR_WIDTH;
  localparam int unsigned ADDR_BITS             = 18;
  localparam int unsigned COUNT_BITS            = 16;

  localparam int unsigned ARITH_INSTR_BITS = 10;
  localparam int unsigned RAM_INSTR_BITS   = 9;
  localparam int unsigned LD_ST_INSTR_BITS = 10;

  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd0;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd1;
  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd2;

endpackage

// File: rtl/iq_issuer.sv
// iq_issuer: producer side of the instruction_queue push port.
// Accepts one loop descriptor per in_valid/in_ready handshake and unrolls it
// into pushes of up to SUPERSCALAR_WIDTH copies, one push per cycle. When the
// queue raises iq_needs_reset the issuer stalls, waits for the queue to drain,
// pulses iq_flush for one cycle, then resumes the descriptor where it stopped.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   descriptor handshake
//   in_instr_type         descriptor type (INSTR_TYPE_*)
//   in_*_instr            opcode fields, one per type
//   in_cache_addr, in_main_mem_addr        base addresses
//   in_d_cache_addr, in_d_main_mem_addr    per-iteration strides
//   in_count              iteration count (0 = no-op)
//   iq_we                 push strobe
//   iq_instr_type, iq_copy_count, iq_*_addr, iq_*_instr   push payload
//   iq_needs_reset        queue requests a stall/drain/flush sequence
//   iq_empty              queue fully drained
//   iq_flush              one-cycle pulse restarting queue positions
//   busy                  issuer not idle
module iq_issuer
  import cherry_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_instr_type,
  input  logic [ARITH_INSTR_BITS-1:0]      in_arith_instr,
  input  logic [RAM_INSTR_BITS-1:0]        in_ram_instr,
  input  logic [LD_ST_INSTR_BITS-1:0]      in_ld_st_instr,
  input  logic [ADDR_BITS-1:0]             in_cache_addr,
  input  logic [ADDR_BITS-1:0]             in_main_mem_addr,
  input  logic [ADDR_BITS-1:0]             in_d_cache_addr,
  input  logic [ADDR_BITS-1:0]             in_d_main_mem_addr,
  input  logic [COUNT_BITS-1:0]            in_count,
  output logic                             iq_we,
  output logic [1:0]                       iq_instr_type,
  output logic [LOG_SUPERSCALAR_WIDTH-1:0] iq_copy_count,
  output logic [ADDR_BITS-1:0]             iq_cache_addr,
  output logic [ADDR_BITS-1:0]             iq_main_mem_addr,
  output logic [ADDR_BITS-1:0]             iq_d_cache_addr,
  output logic [ADDR_BITS-1:0]             iq_d_main_mem_addr,
  output logic [ARITH_INSTR_BITS-1:0]      iq_arith_instr,
  output logic [RAM_INSTR_BITS-1:0]        iq_ram_instr,
  output logic [LD_ST_INSTR_BITS-1:0]      iq_ld_st_instr,
  input  logic                             iq_needs_reset,
  input  logic                             iq_empty,
  output logic                             iq_flush,
  output logic                             busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFlush} state_e;

  state_e                        state_q;
  logic [COUNT_BITS-1:0]         rem_q;
  logic [1:0]                    type_q;
  logic [ARITH_INSTR_BITS-1:0]   arith_q;
  logic [RAM_INSTR_BITS-1:0]     ram_q;
  logic [LD_ST_INSTR_BITS-1:0]   ld_st_q;
  logic [ADDR_BITS-1:0]          cache_q;
  logic [ADDR_BITS-1:0]          main_mem_q;
  logic [ADDR_BITS-1:0]          d_cache_q;
  logic [ADDR_BITS-1:0]          d_main_mem_q;

  logic                          last_push;
  logic [COUNT_BITS-1:0]         push_n;
  logic [COUNT_BITS-1:0]         push_n_m1;
  logic [ADDR_BITS-1:0]          cache_step;
  logic [ADDR_BITS-1:0]          main_mem_step;

  // The final push of a descriptor carries whatever is left (1..16 copies).
  assign last_push     = (rem_q <= COUNT_BITS'(SUPERSCALAR_WIDTH));
  assign push_n        = last_push ? rem_q : COUNT_BITS'(SUPERSCALAR_WIDTH);
  assign push_n_m1     = push_n - COUNT_BITS'(1);
  // A push covers SUPERSCALAR_WIDTH iterations, so the base advances by stride*16;
  // the 18-bit result wraps modulo the address space.
  assign cache_step    = d_cache_q << LOG_SUPERSCALAR_WIDTH;
  assign main_mem_step = d_main_mem_q << LOG_SUPERSCALAR_WIDTH;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      type_q       <= '0;
      arith_q      <= '0;
      ram_q        <= '0;
      ld_st_q      <= '0;
      cache_q      <= '0;
      main_mem_q   <= '0;
      d_cache_q    <= '0;
      d_main_mem_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (iq_needs_reset) begin
            state_q <= StDrain;
          end else if (in_valid) begin
            type_q       <= in_instr_type;
            arith_q      <= in_arith_instr;
            ram_q        <= in_ram_instr;
            ld_st_q      <= in_ld_st_instr;
            cache_q      <= in_cache_addr;
            main_mem_q   <= in_main_mem_addr;
            d_cache_q    <= in_d_cache_addr;
            d_main_mem_q <= in_d_main_mem_addr;
            rem_q        <= in_count;
            if (in_count != '0) state_q <= StIssue;
          end
        end
        StIssue: begin
          // A stalled cycle leaves rem/cur untouched so the push is replayed after flush.
          if (iq_needs_reset) begin
            state_q <= StDrain;
          end else begin
            cache_q    <= cache_q + cache_step;
            main_mem_q <= main_mem_q + main_mem_step;
            rem_q      <= rem_q - push_n;
            if (last_push) state_q <= StIdle;
          end
        end
        StDrain: begin
          if (iq_empty) state_q <= StFlush;
        end
        StFlush: begin
          state_q <= (rem_q != '0) ? StIssue : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = (state_q == StIdle) && !iq_needs_reset && !reset;
  assign iq_we    = (state_q == StIssue) && !iq_needs_reset && !reset;
  assign iq_flush = (state_q == StFlush) && !reset;
  assign busy     = (state_q != StIdle) && !reset;

  assign iq_instr_type      = type_q;
  assign iq_copy_count      = push_n_m1[LOG_SUPERSCALAR_WIDTH-1:0];
  assign iq_cache_addr      = cache_q;
  assign iq_main_mem_addr   = main_mem_q;
  assign iq_d_cache_addr    = d_cache_q;
  assign iq_d_main_mem_addr = d_main_mem_q;

  // Only the opcode field matching the pushed type is presented; the rest read 0.
  always_comb begin
    iq_arith_instr = '0;
    iq_ram_instr   = '0;
    iq_ld_st_instr = '0;
    case (type_q)
      INSTR_TYPE_ARITHMETIC: iq_arith_instr = arith_q;
      INSTR_TYPE_RAM:        iq_ram_instr   = ram_q;
      INSTR_TYPE_LOAD_STORE: iq_ld_st_instr = ld_st_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iq_issuer.sv
// Self-checking bench for iq_issuer. Expected pushes are generated from each
// descriptor when it is driven and compared in order as iq_we pulses appear.
module tb_iq_issuer;
  import cherry_pkg::*;

  typedef struct packed {
    logic [1:0]  itype;
    logic [3:0]  copy;
    logic [17:0] cache;
    logic [17:0] mm;
    logic [17:0] dcache;
    logic [17:0] dmm;
    logic [9:0]  arith;
    logic [8:0]  ram;
    logic [9:0]  ldst;
  } push_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_instr_type;
  logic [9:0]  in_arith_instr;
  logic [8:0]  in_ram_instr;
  logic [9:0]  in_ld_st_instr;
  logic [17:0] in_cache_addr, in_main_mem_addr, in_d_cache_addr, in_d_main_mem_addr;
  logic [15:0] in_count;
  logic        iq_we;
  logic [1:0]  iq_instr_type;
  logic [3:0]  iq_copy_count;
  logic [17:0] iq_cache_addr, iq_main_mem_addr, iq_d_cache_addr, iq_d_main_mem_addr;
  logic [9:0]  iq_arith_instr;
  logic [8:0]  iq_ram_instr;
  logic [9:0]  iq_ld_st_instr;
  logic        iq_needs_reset;
  logic        iq_empty;
  logic        iq_flush;
  logic        busy;

  push_t sb[$];
  push_t mon_act, mon_exp;
  int    checks = 0;
  int    failures = 0;
  int    push_cnt = 0;
  int    flush_cnt = 0;

  iq_issuer dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_instr_type      (in_instr_type),
    .in_arith_instr     (in_arith_instr),
    .in_ram_instr       (in_ram_instr),
    .in_ld_st_instr     (in_ld_st_instr),
    .in_cache_addr      (in_cache_addr),
    .in_main_mem_addr   (in_main_mem_addr),
    .in_d_cache_addr    (in_d_cache_addr),
    .in_d_main_mem_addr (in_d_main_mem_addr),
    .in_count           (in_count),
    .iq_we              (iq_we),
    .iq_instr_type      (iq_instr_type),
    .iq_copy_count      (iq_copy_count),
    .iq_cache_addr      (iq_cache_addr),
    .iq_main_mem_addr   (iq_main_mem_addr),
    .iq_d_cache_addr    (iq_d_cache_addr),
    .iq_d_main_mem_addr (iq_d_main_mem_addr),
    .iq_arith_instr     (iq_arith_instr),
    .iq_ram_instr       (iq_ram_instr),
    .iq_ld_st_instr     (iq_ld_st_instr),
    .iq_needs_reset     (iq_needs_reset),
    .iq_empty           (iq_empty),
    .iq_flush           (iq_flush),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Push monitor: sample on the falling edge, compare against the scoreboard head.
  always @(negedge clk) begin
    if (iq_flush) flush_cnt++;
    if (iq_we) begin
      push_cnt++;
      mon_act = {iq_instr_type, iq_copy_count, iq_cache_addr, iq_main_mem_addr,
                 iq_d_cache_addr, iq_d_main_mem_addr, iq_arith_instr, iq_ram_instr,
                 iq_ld_st_instr};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_push actual=%h required=no push", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL push_payload actual=%h required=%h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Drives one descriptor; caller and return are aligned 1 time unit after a rising edge.
  task automatic send(input logic [1:0] t, input logic [9:0] ar, input logic [8:0] rm,
                      input logic [9:0] ls, input logic [17:0] ca, input logic [17:0] mm,
                      input logic [17:0] dca, input logic [17:0] dmm, input logic [15:0] cnt,
                      input bit model);
    int guard = 0;
    logic [15:0] rem;
    logic [17:0] c, m;
    push_t e;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_ready_timeout actual=%b required=1", in_ready);
    end
    in_instr_type = t; in_arith_instr = ar; in_ram_instr = rm; in_ld_st_instr = ls;
    in_cache_addr = ca; in_main_mem_addr = mm; in_d_cache_addr = dca;
    in_d_main_mem_addr = dmm; in_count = cnt; in_valid = 1'b1;
    if (model) begin
      rem = cnt; c = ca; m = mm;
      while (rem != 0) begin
        e = '0;
        e.itype  = t;
        e.copy   = (rem >= 16) ? 4'd15 : 4'(rem - 16'd1);
        e.cache  = c;
        e.mm     = m;
        e.dcache = dca;
        e.dmm    = dmm;
        if (t == INSTR_TYPE_ARITHMETIC) e.arith = ar;
        if (t == INSTR_TYPE_RAM)        e.ram   = rm;
        if (t == INSTR_TYPE_LOAD_STORE) e.ldst  = ls;
        sb.push_back(e);
        c = c + {dca[13:0], 4'b0000};
        m = m + {dmm[13:0], 4'b0000};
        rem = (rem >= 16) ? rem - 16'd16 : 16'd0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || sb.size() != 0) && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      failures++;
      $display("FAIL wait_idle actual=busy%b pending%0d required=idle,0", busy, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; iq_needs_reset = 1'b0; iq_empty = 1'b0;
    in_instr_type = '0; in_arith_instr = '0; in_ram_instr = '0; in_ld_st_instr = '0;
    in_cache_addr = '0; in_main_mem_addr = '0; in_d_cache_addr = '0;
    in_d_main_mem_addr = '0; in_count = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({iq_we, iq_flush, busy, in_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs actual=%b required=0000", {iq_we, iq_flush, busy, in_ready});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release actual=%b required=10", {in_ready, busy});
    end
    checks++;
    if ({iq_cache_addr, iq_main_mem_addr} !== 36'd0) begin
      failures++;
      $display("FAIL reset_addrs actual=%h required=0", {iq_cache_addr, iq_main_mem_addr});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_arith_40();
    int p0 = push_cnt;
    send(INSTR_TYPE_ARITHMETIC, 10'h155, 9'h1AA, 10'h2AA, 18'h100, 18'h2000,
         18'd2, 18'd3, 16'd40, 1);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL arith40_busy2 actual=%b required=1", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL arith40_busy3 actual=%b required=1", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || push_cnt - p0 != 3) begin
      failures++;
      $display("FAIL arith40_done actual=busy%b pushes%0d required=busy0 pushes3",
               busy, push_cnt - p0);
    end
    wait_idle();
  endtask

  task automatic test_count16_and_1();
    int p0 = push_cnt;
    send(INSTR_TYPE_ARITHMETIC, 10'h3C3, 9'h0, 10'h0, 18'h2AAAA, 18'h15555,
         18'h7, 18'h9, 16'd16, 1);
    @(posedge clk); #1;
    checks++;
    if ({busy, in_ready} !== 2'b01 || push_cnt - p0 != 1) begin
      failures++;
      $display("FAIL count16_idle actual=busy%b rdy%b pushes%0d required=busy0 rdy1 pushes1",
               busy, in_ready, push_cnt - p0);
    end
    p0 = push_cnt;
    send(INSTR_TYPE_LOAD_STORE, 10'h111, 9'h1FF, 10'h2C5, 18'h00040, 18'h00080,
         18'h1, 18'h2, 16'd1, 1);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || push_cnt - p0 != 1) begin
      failures++;
      $display("FAIL count1_idle actual=busy%b pushes%0d required=busy0 pushes1",
               busy, push_cnt - p0);
    end
  endtask

  task automatic test_count0();
    int p0 = push_cnt;
    send(INSTR_TYPE_RAM, 10'h0, 9'h0AB, 10'h0, 18'h100, 18'h200, 18'h1, 18'h1, 16'd0, 1);
    checks++;
    if ({busy, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL count0_ready actual=busy%b rdy%b required=busy0 rdy1", busy, in_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (push_cnt != p0) begin
      failures++; $display("FAIL count0_nopush actual=%0d required=0", push_cnt - p0);
    end
  endtask

  task automatic test_needs_reset();
    int p0 = push_cnt;
    int f0 = flush_cnt;
    send(INSTR_TYPE_RAM, 10'h0, 9'h0CD, 10'h0, 18'h01000, 18'h20000,
         18'h4, 18'h8, 16'd48, 1);
    @(posedge clk); #1;
    iq_needs_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (iq_we !== 1'b0 || push_cnt - p0 != 1) begin
      failures++;
      $display("FAIL stall_we actual=we%b pushes%0d required=we0 pushes1", iq_we, push_cnt - p0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, iq_we, iq_flush} !== 3'b100) begin
        failures++;
        $display("FAIL drain_hold actual=%b required=100", {busy, iq_we, iq_flush});
      end
      @(posedge clk); #1;
    end
    iq_empty = 1'b1;
    @(posedge clk); #1;
    iq_empty = 1'b0;
    iq_needs_reset = 1'b0;
    checks++;
    if (iq_flush !== 1'b1 || iq_we !== 1'b0) begin
      failures++;
      $display("FAIL flush_pulse actual=flush%b we%b required=flush1 we0", iq_flush, iq_we);
    end
    wait_idle();
    checks++;
    if (flush_cnt - f0 != 1 || push_cnt - p0 != 3) begin
      failures++;
      $display("FAIL flush_resume actual=flushes%0d pushes%0d required=flushes1 pushes3",
               flush_cnt - f0, push_cnt - p0);
    end
  endtask

  task automatic test_wrap();
    send(INSTR_TYPE_LOAD_STORE, 10'h0, 9'h0, 10'h3A5, 18'h30000, 18'h3FFF0,
         18'h10, 18'h1, 16'd32, 1);
    @(posedge clk); #1;
    checks++;
    if (iq_main_mem_addr !== 18'h00000) begin
      failures++; $display("FAIL wrap_addr actual=%h required=00000", iq_main_mem_addr);
    end
    wait_idle();
  endtask

  task automatic test_idle_needs_reset();
    int f0 = flush_cnt;
    iq_needs_reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL idle_nr_ready actual=%b required=0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL idle_nr_drain actual=%b required=1", busy);
    end
    iq_needs_reset = 1'b0;
    iq_empty = 1'b1;
    @(posedge clk); #1;
    iq_empty = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, iq_flush, in_ready} !== 3'b001 || flush_cnt - f0 != 1) begin
      failures++;
      $display("FAIL idle_nr_back actual=%b flushes%0d required=001 flushes1",
               {busy, iq_flush, in_ready}, flush_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = push_cnt;
    send(INSTR_TYPE_RAM, 10'h0, 9'h155, 10'h0, 18'h00500, 18'h00600,
         18'h3, 18'h5, 16'd20, 1);
    send(INSTR_TYPE_ARITHMETIC, 10'h2F0, 9'h0, 10'h0, 18'h3FF00, 18'h01000,
         18'h20, 18'h2, 16'd17, 1);
    wait_idle();
    checks++;
    if (push_cnt - p0 != 4) begin
      failures++; $display("FAIL b2b_pushes actual=%0d required=4", push_cnt - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0 = push_cnt;
    send(INSTR_TYPE_ARITHMETIC, 10'h1, 9'h0, 10'h0, 18'h0, 18'h0, 18'h1, 18'h1, 16'd32, 0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({iq_we, iq_flush} !== 2'b00) begin
      failures++; $display("FAIL midreset_during actual=%b required=00", {iq_we, iq_flush});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({iq_we, busy, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL midreset_after actual=%b required=001", {iq_we, busy, in_ready});
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (push_cnt != p0 || iq_flush !== 1'b0) begin
      failures++;
      $display("FAIL midreset_nopush actual=pushes%0d flush%b required=0,0",
               push_cnt - p0, iq_flush);
    end
  endtask

  initial begin
    test_reset();
    test_arith_40();
    test_count16_and_1();
    test_count0();
    test_needs_reset();
    test_wrap();
    test_idle_needs_reset();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
